// File: rtl/pingpong_pixel_buf.sv
// Double-banked pixel line buffer. The write side fills one bank while the
// display side drains the other. Banks swap when a line closes (write side)
// or when its final pixel is read (read side). Each bank carries a full flag
// and a line length. Overflow and underflow are sticky error flags.
module pingpong_pixel_buf #(
  parameter  int DATA_W = 32,
  parameter  int CH_W   = 8,
  parameter  int NUM_CH = 3,
  parameter  int DEPTH  = 100,
  parameter  int ADDR_W = 20,
  localparam int PIX_W  = NUM_CH * CH_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  input  logic              rd_en,
  output logic              rd_avail,
  output logic              rd_valid,
  output logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  rd_ch,
  output logic              rd_last,
  output logic [ADDR_W-1:0] line_len,
  output logic              wsel,
  output logic              rsel,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PIX_W-1:0]  bank0_mem [DEPTH];
  logic [PIX_W-1:0]  bank1_mem [DEPTH];

  logic [1:0]        full;
  logic [ADDR_W-1:0] len [2];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;

  logic              wr_acc;
  logic              wr_close;
  logic              rd_acc;
  logic              rd_rel;
  logic [ADDR_W-1:0] rd_len_m1;
  logic [PIX_W-1:0]  wr_pix;
  logic [PIX_W-1:0]  rd_pix;

  // Only the low PIX_W bits of the bus carry a pixel.
  generate
    if (DATA_W > PIX_W) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = ^wr_data[DATA_W-1:PIX_W];
    end
  endgenerate

  // Status is a function of the bank state only, never of the requests.
  assign wr_ready = !full[wsel];
  assign rd_avail = full[rsel];
  assign line_len = len[rsel];
  assign rd_ch    = rd_data;
  assign wr_pix   = wr_data[PIX_W-1:0];

  // Accept/close/release decisions for the current cycle.
  always_comb begin
    wr_acc    = wr_en & wr_ready;
    wr_close  = wr_acc & (wr_last | (wptr == PTR_W'(DEPTH - 1)));
    rd_acc    = rd_en & rd_avail;
    rd_len_m1 = line_len - ADDR_W'(1);
    rd_rel    = rd_acc & (ADDR_W'(rptr) == rd_len_m1);
    rd_pix    = rsel ? bank1_mem[rptr] : bank0_mem[rptr];
  end

  // Pixel storage; contents are not reset.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      if (wsel) bank1_mem[wptr] <= wr_pix;
      else      bank0_mem[wptr] <= wr_pix;
    end
  end

  // Write pointer, write bank select and per-bank line length.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr   <= '0;
      wsel   <= 1'b0;
      len[0] <= '0;
      len[1] <= '0;
    end else if (wr_close) begin
      len[wsel] <= ADDR_W'(wptr) + ADDR_W'(1);
      wptr      <= '0;
      wsel      <= ~wsel;
    end else if (wr_acc) begin
      wptr <= wptr + PTR_W'(1);
    end
  end

  // Full flags: a closing write and a releasing read always hit different
  // banks, so both may update in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full <= 2'b00;
    end else begin
      if (wr_close) full[wsel] <= 1'b1;
      if (rd_rel)   full[rsel] <= 1'b0;
    end
  end

  // Read pointer, read bank select and the registered pixel outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rptr     <= '0;
      rsel     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      rd_last  <= rd_rel;
      if (rd_acc) begin
        rd_data <= rd_pix;
        if (rd_rel) begin
          rptr <= '0;
          rsel <= ~rsel;
        end else begin
          rptr <= rptr + PTR_W'(1);
        end
      end
    end
  end

  // Sticky error flags; a clear wins over a same-cycle set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (err_clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & !wr_ready) overflow  <= 1'b1;
      if (rd_en & !rd_avail) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pingpong_pixel_buf.sv
// Bench for pingpong_pixel_buf with DEPTH=4. A queue-based line model
// predicts every output; directed steps cover the documented scenarios and a
// random phase mixes writes, reads and error clears.
module tb_pingpong_pixel_buf;

  localparam int DATA_W = 32;
  localparam int CH_W   = 8;
  localparam int NUM_CH = 3;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 20;
  localparam int PIX_W  = NUM_CH * CH_W;

  logic              clock;
  logic              reset;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              wr_ready;
  logic              rd_en;
  logic              rd_avail;
  logic              rd_valid;
  logic [PIX_W-1:0]  rd_data;
  logic [PIX_W-1:0]  rd_ch;
  logic              rd_last;
  logic [ADDR_W-1:0] line_len;
  logic              wsel;
  logic              rsel;
  logic              overflow;
  logic              underflow;
  logic              err_clr;

  pingpong_pixel_buf #(
    .DATA_W(DATA_W), .CH_W(CH_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_avail(rd_avail), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_ch(rd_ch), .rd_last(rd_last), .line_len(line_len),
    .wsel(wsel), .rsel(rsel), .overflow(overflow), .underflow(underflow),
    .err_clr(err_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: completed lines waiting/being read, plus the open line.
  logic [PIX_W-1:0] pix_q [$];
  int               len_q [$];
  logic [PIX_W-1:0] cur_q [$];
  int               rd_idx;
  int               wlines;
  int               rlines;
  bit               m_ovf, m_udf, m_valid, m_last;
  logic [PIX_W-1:0] m_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pix_q.delete();
    len_q.delete();
    cur_q.delete();
    rd_idx  = 0;
    wlines  = 0;
    rlines  = 0;
    m_ovf   = 0;
    m_udf   = 0;
    m_valid = 0;
    m_last  = 0;
    m_data  = '0;
  endtask

  task automatic check_all();
    chk("wr_ready", wr_ready, len_q.size() < 2);
    chk("rd_avail", rd_avail, len_q.size() > 0);
    if (len_q.size() > 0) chk("line_len", line_len, len_q[0]);
    chk("wsel", wsel, wlines % 2);
    chk("rsel", rsel, rlines % 2);
    chk("rd_valid", rd_valid, m_valid);
    chk("rd_last", rd_last, m_last);
    chk("rd_data", rd_data, m_data);
    chk("rd_ch", rd_ch, m_data);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_udf);
  endtask

  // One clock: drive at the falling edge, update the model, check after the
  // next falling edge.
  task automatic step(input logic we, input logic [31:0] wd, input logic wl,
                      input logic re, input logic ec);
    bit wr_ok, rd_ok;
    wr_ok   = we && (len_q.size() < 2);
    rd_ok   = re && (len_q.size() > 0);
    wr_en   = we;
    wr_data = wd;
    wr_last = wl;
    rd_en   = re;
    err_clr = ec;
    m_valid = rd_ok;
    m_last  = 0;
    if (rd_ok) begin
      m_data = pix_q.pop_front();
      rd_idx++;
      if (rd_idx == len_q[0]) begin
        void'(len_q.pop_front());
        rd_idx = 0;
        m_last = 1;
        rlines++;
      end
    end
    if (wr_ok) begin
      cur_q.push_back(wd[PIX_W-1:0]);
      if (wl || cur_q.size() == DEPTH) begin
        len_q.push_back(cur_q.size());
        foreach (cur_q[i]) pix_q.push_back(cur_q[i]);
        cur_q.delete();
        wlines++;
      end
    end
    if (ec) begin
      m_ovf = 0;
      m_udf = 0;
    end else begin
      if (we && !wr_ok) m_ovf = 1;
      if (re && !rd_ok) m_udf = 1;
    end
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    wr_last = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_all();

    // Three-pixel line, then drain it and inspect channel fields.
    step(1'b1, 32'h00AABBCC, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00112233, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00445566, 1'b1, 1'b0, 1'b0);
    chk("t1_len", line_len, 3);
    chk("t1_wsel", wsel, 1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("t1_ch0a", rd_ch[7:0], 8'hCC);
    chk("t1_ch1a", rd_ch[15:8], 8'hBB);
    chk("t1_ch2a", rd_ch[23:16], 8'hAA);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("t1_ch0b", rd_ch[7:0], 8'h33);
    chk("t1_ch2b", rd_ch[23:16], 8'h11);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("t1_ch1c", rd_ch[15:8], 8'h55);
    chk("t1_last", rd_last, 1);
    chk("t1_rsel", rsel, 1);
    chk("t1_avail", rd_avail, 0);

    // Read from an empty buffer.
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("t3_valid", rd_valid, 0);
    chk("t3_udf", underflow, 1);
    idle();

    // Fill both banks, drop one write, drain back to back, clear errors.
    for (int i = 0; i < 8; i++) step(1'b1, 32'hA000_0000 + 32'(i * 16'h1111), 1'b0, 1'b0, 1'b0);
    chk("t2_ready", wr_ready, 0);
    step(1'b1, 32'h00FFFFFF, 1'b0, 1'b0, 1'b0);
    chk("t2_ovf", overflow, 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("t2_data", rd_data, 24'(i * 16'h1111));
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("t2_clr_ovf", overflow, 0);
    chk("t2_clr_udf", underflow, 0);

    // Final read of one bank coincides with the close of the other.
    step(1'b1, 32'h00000101, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00000202, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h00000303, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00000404, 1'b1, 1'b1, 1'b0);
    chk("t4_last", rd_last, 1);
    chk("t4_ready", wr_ready, 1);
    chk("t4_avail", rd_avail, 1);
    chk("t4_len", line_len, 2);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Upper bus bits are ignored; single-pixel line.
    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    chk("t6_len", line_len, 1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("t6_data", rd_data, 24'hADBEEF);
    chk("t6_last", rd_last, 1);

    // Asynchronous reset in the middle of a line.
    step(1'b1, 32'h00000011, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00000022, 1'b0, 1'b0, 1'b0);
    wr_en   = 1'b1;
    wr_data = 32'h00000033;
    #2 reset = 1'b1;
    #1;
    chk("t5_ready", wr_ready, 1);
    chk("t5_avail", rd_avail, 0);
    chk("t5_valid", rd_valid, 0);
    chk("t5_data", rd_data, 0);
    chk("t5_ch", rd_ch, 0);
    chk("t5_last", rd_last, 0);
    chk("t5_len", line_len, 0);
    chk("t5_wsel", wsel, 0);
    chk("t5_rsel", rsel, 0);
    chk("t5_ovf", overflow, 0);
    chk("t5_udf", underflow, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    wr_en = 1'b0;
    check_all();
    step(1'b1, 32'h00ABCDEF, 1'b1, 1'b0, 1'b0);
    chk("t5_len1", line_len, 1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("t5_rd", rd_data, 24'hABCDEF);
    chk("t5_rdlast", rd_last, 1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 7) == 0,
           $urandom_range(0, 99) < 55, $urandom_range(0, 39) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pingpong_pixel_buf.md
Name: pingpong_pixel_buf

Overview:
Parametrised double-banked (ping-pong) pixel line buffer for the display adaptor datapath.
- The write side fills one bank from the 32-bit bus while the display side drains the other bank.
- Drained pixels are split into per-channel colour fields.
- Banks swap automatically on line completion, with back-pressure, read-ahead status and sticky error flags.
- Generalises the earlier single-bank buffer: width, depth and channel count are parameters, and the block adds bank swapping, flow control and line framing.

Parameters:
DATA_W, 32, write bus width; must be >= NUM_CH*CH_W.
CH_W, 8, bits per colour channel.
NUM_CH, 3, channels per pixel; pixel width PIX_W = NUM_CH*CH_W.
DEPTH, 100, pixel entries per bank; must be >= 2.
ADDR_W, 20, width of the length output; must satisfy 2^ADDR_W > DEPTH.

Ports:
clock  in  1  single clock; all state updates on its rising edge only.
reset  in  1  asynchronous, active-high reset.
wr_en  in  1  write request.
wr_data  in  DATA_W  pixel word; bits [PIX_W-1:0] are stored, upper bits are ignored.
wr_last  in  1  qualifies wr_en; marks the final pixel of a line.
wr_ready  out  1  write bank can accept a pixel.
rd_en  in  1  read request.
rd_avail  out  1  read bank holds a complete line.
rd_valid  out  1  rd_data/rd_ch/rd_last are valid this cycle.
rd_data  out  PIX_W  full pixel.
rd_ch  out  PIX_W  same pixel; channel k occupies [k*CH_W +: CH_W]; channel 0 = bits [CH_W-1:0].
rd_last  out  1  with rd_valid, marks the final pixel of the line.
line_len  out  ADDR_W  pixel count of the bank currently being read.
wsel  out  1  bank index being written.
rsel  out  1  bank index being read.
overflow  out  1  sticky: a write was dropped.
underflow  out  1  sticky: a read was refused.
err_clr  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Storage: two banks of DEPTH x PIX_W. Per bank b, keep full[b] and len[b]. Internal pointers: wptr, rptr.
- Reset (asynchronous, takes effect immediately, including mid-line), all to zero: full, len, wptr, rptr, wsel, rsel, rd_valid, rd_data, rd_ch, rd_last, overflow, underflow. Memory contents are don't-care.
- wr_ready = !full[wsel]. This is combinational from state only, never from wr_en.
- Accepted write (wr_en & wr_ready): store into bank wsel at wptr.
  - If wr_last or wptr == DEPTH-1 (bank closes): full[wsel] <= 1, len[wsel] <= wptr+1, wptr <= 0, wsel toggles.
  - Otherwise: wptr increments.
- Dropped write (wr_en & !wr_ready): no state change; overflow <= 1.
- rd_avail = full[rsel]; line_len = len[rsel].
- Accepted read (rd_en & rd_avail): memory is read at rptr, and the registered outputs update next cycle (latency 1): rd_valid = 1, rd_data = rd_ch = stored pixel.
  - If rptr == len[rsel]-1 (bank releases): rd_last = 1, full[rsel] <= 0, rptr <= 0, rsel toggles.
  - Otherwise: rptr increments, rd_last = 0.
- Refused read (rd_en & !rd_avail): rd_valid = 0 next cycle; underflow <= 1.
- With no read accepted, rd_valid drops to 0 next cycle. rd_data/rd_ch hold their last value; rd_last clears.
- Back-to-back reads give one pixel per cycle, continuing across the bank swap without a bubble if the other bank is already full.
- Simultaneous write-close and read-release: these always target different banks, because a write requires !full and a read requires full. Both take effect in the same cycle.
- Write into a bank that is released in the same cycle is impossible: it is not writable until the cycle after release. wr_ready rises in the cycle after rd_last's read is accepted.
- err_clr takes priority over a same-cycle set of overflow/underflow. Flags are cleared, not re-set.
- wr_last with wptr == DEPTH-1 behaves as a single close; len = DEPTH.
- One-pixel line (wr_last on the first write): len = 1. The first read of that bank also asserts rd_last.

Test Plan:
- DEPTH=4. Reset, then 3 writes 0x00AABBCC, 0x00112233, 0x00445566 with wr_last on the third -> wsel=1, rd_avail=1, line_len=3. Three reads give rd_ch ch0=CC/ch1=BB/ch2=AA, then 33/22/11, then 66/55/44; rd_last on the third; rsel=1; rd_avail=0.
- DEPTH=4. 8 consecutive writes without wr_last -> both banks full after 8 writes, wr_ready=0. A 9th write is dropped and sets overflow=1. Eight back-to-back reads return the 8 values in order with no bubble and rd_last on reads 4 and 8. err_clr then clears overflow.
- Empty buffer, rd_en pulse -> rd_valid stays 0, underflow=1, rptr unchanged.
- Bank 0 full and draining while bank 1 closes on the same cycle that bank 0's final read is accepted -> full becomes {1,0}, rsel=1, wsel=0, wr_ready=1 next cycle.
- Reset asserted mid-write of line 2 (wptr=2, asynchronous, between edges) -> all outputs go to 0 immediately. The next line written after reset starts at bank 0, entry 0.
- Write wr_data=0xDEADBEEF with NUM_CH=3, wr_last=1 -> rd_data=0xADBEEF, line_len=1, rd_last=1 on the first read.
